// File: rtl/soda_display_sequencer.sv
// Front-panel text scheduler: round-robin arbitration between credit, price
// and change amounts, then streams a 5-byte ASCII frame (tag, three digits,
// line end) over a valid/ready byte link.
module soda_display_sequencer #(
    parameter logic [7:0] LINE_END = 8'h0D,
    parameter bit         BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [9:0] bcd0,
    input  logic [9:0] bcd1,
    input  logic [9:0] bcd2,
    output logic [2:0] grant,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t     state_r, state_s;
    logic [2:0] idx_r, idx_s;
    logic [1:0] last_r, last_s;
    logic [9:0] val_r, val_s;
    logic [1:0] src_r, src_s;
    logic [2:0] pick_s;
    logic [2:0] grant_r, grant_s;
    logic [7:0] tx_data_r, tx_data_s;
    logic       tx_valid_r;
    logic       frame_done_r, frame_done_s;

    // One BCD nibble to ASCII; non-decimal nibbles show as a space.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        logic [7:0] b;
        if (d <= 4'd9) begin
            b = 8'h30 + {4'h0, d};
        end else begin
            b = 8'h20;
        end
        return b;
    endfunction

    // Byte at a given frame position for the snapshotted source and value.
    function automatic logic [7:0] frame_byte(input logic [1:0] src,
                                              input logic [9:0] val,
                                              input logic [2:0] idx);
        logic       hz;
        logic [7:0] b;
        hz = BLANK_LZ && (val[9:8] == 2'd0);
        case (idx)
            3'd0: begin
                case (src)
                    2'd0:    b = 8'h43;
                    2'd1:    b = 8'h50;
                    2'd2:    b = 8'h52;
                    default: b = 8'h43;
                endcase
            end
            3'd1:    b = hz ? 8'h20 : digit_ascii({2'b00, val[9:8]});
            3'd2:    b = (hz && (val[7:4] == 4'd0)) ? 8'h20 : digit_ascii(val[7:4]);
            3'd3:    b = digit_ascii(val[3:0]);
            3'd4:    b = LINE_END;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Round-robin pick: first set request after the last winner, one-hot.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] p;
        logic [1:0] c;
        p = 3'b000;
        c = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if ((p == 3'b000) && r[c]) begin
                p[c] = 1'b1;
            end
            c = (c >= 2'd2) ? 2'd0 : c + 2'd1;
        end
        return p;
    endfunction

    // Next-state, snapshot and next-output decode.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        last_s       = last_r;
        val_s        = val_r;
        src_s        = src_r;
        grant_s      = 3'b000;
        frame_done_s = 1'b0;
        pick_s       = rr_pick(req, last_r);
        case (state_r)
            IDLE: begin
                if (pick_s != 3'b000) begin
                    state_s = SEND;
                    idx_s   = 3'd0;
                    grant_s = pick_s;
                    case (pick_s)
                        3'b001:  begin src_s = 2'd0; val_s = bcd0; end
                        3'b010:  begin src_s = 2'd1; val_s = bcd1; end
                        3'b100:  begin src_s = 2'd2; val_s = bcd2; end
                        default: begin src_s = src_r; val_s = val_r; end
                    endcase
                    last_s = src_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_r == 3'd4) begin
                        state_s      = IDLE;
                        idx_s        = 3'd0;
                        frame_done_s = 1'b1;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
            end
        endcase
        tx_data_s = (state_s == SEND) ? frame_byte(src_s, val_s, idx_s) : 8'h00;
    end

    // State, snapshot and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= 3'd0;
            last_r       <= 2'd2;
            val_r        <= 10'd0;
            src_r        <= 2'd0;
            grant_r      <= 3'b000;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            last_r       <= last_s;
            val_r        <= val_s;
            src_r        <= src_s;
            grant_r      <= grant_s;
            tx_data_r    <= tx_data_s;
            tx_valid_r   <= (state_s == SEND);
            frame_done_r <= frame_done_s;
        end
    end

    assign grant      = grant_r;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign busy       = tx_valid_r;
    assign frame_done = frame_done_r;

endmodule
